// File: rtl/proc_pkg.sv
// Shared encodings for the basic-CPU instruction sequencer: opcodes, step states
// and bus-mux select bit positions.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    localparam int SEL_DIN = 0;
    localparam int SEL_G   = 1;
    localparam int SEL_R0  = 2;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Instruction-sequencing FSM: captures a 9-bit instruction in T0 and steps the
// datapath (bus mux select, register/A/G loads, add/sub mode) through T1..T3.
module proc_control
    import proc_pkg::*;
#(
    parameter int WORD = 16,
    parameter int NREG = 8
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            run,
    input  logic [WORD-1:0] din,
    input  logic            g_nz,
    output logic [NREG+1:0] select,
    output logic [NREG-1:0] rin,
    output logic            ain,
    output logic            gin,
    output logic            addsub,
    output logic [8:0]      ir,
    output logic            busy,
    output logic            done
);

    state_e     state_q, state_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] opcode, rx, ry;
    logic       sel_din, sel_g;
    logic       rsel_en, rsel_use_ry;
    logic       rin_en;
    logic [2:0] rsel_idx;
    logic [7:0] sel_regs;
    logic [7:0] rin_dec;

    assign opcode = ir_q[8:6];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        sel_din     = 1'b0;
        sel_g       = 1'b0;
        rsel_en     = 1'b0;
        rsel_use_ry = 1'b0;
        rin_en      = 1'b0;
        ain         = 1'b0;
        gin         = 1'b0;
        addsub      = 1'b0;
        done        = 1'b0;

        case (state_q)
            T0: begin
                if (run) begin
                    ir_d    = din[8:0];
                    state_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        rsel_en     = 1'b1;
                        rsel_use_ry = 1'b1;
                        rin_en      = 1'b1;
                        done        = 1'b1;
                    end
                    OP_MVI: begin
                        sel_din = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rsel_en = 1'b1;
                        ain     = 1'b1;
                        state_d = T2;
                    end
                    OP_MVNZ: begin
                        // Conditional move: the step always completes, writes only if G != 0.
                        rsel_en     = g_nz;
                        rsel_use_ry = 1'b1;
                        rin_en      = g_nz;
                        done        = 1'b1;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
            end
            T2: begin
                rsel_en     = 1'b1;
                rsel_use_ry = 1'b1;
                gin         = 1'b1;
                addsub      = (opcode == OP_SUB);
                state_d     = T3;
            end
            T3: begin
                sel_g  = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
            end
            default: begin
                state_d = T0;
            end
        endcase

        if (done) begin
            state_d = T0;
        end
    end

    assign rsel_idx = rsel_use_ry ? ry : rx;

    dec3to8 u_sel_dec (
        .en_i  (rsel_en),
        .sel_i (rsel_idx),
        .dec_o (sel_regs)
    );

    dec3to8 u_rin_dec (
        .en_i  (rin_en),
        .sel_i (rx),
        .dec_o (rin_dec)
    );

    always_comb begin
        select           = '0;
        select[SEL_DIN]  = sel_din;
        select[SEL_G]    = sel_g;
        select[SEL_R0 +: NREG] = sel_regs;
    end

    assign rin  = rin_dec;
    assign ir   = ir_q;
    assign busy = (state_q != T0);

    a_select_onehot0 : assert property (@(posedge clock) disable iff (!resetn) $onehot0(select));
    a_rin_onehot0    : assert property (@(posedge clock) disable iff (!resetn) $onehot0(rin));
    a_gin_rin_excl   : assert property (@(posedge clock) disable iff (!resetn) !(gin && (|rin)));

endmodule

// File: tb/tb_proc_control.sv
// Scenario bench for proc_control: each task drives one cycle per table row and
// checks the observed outputs against expectations queued on a scoreboard.
module tb_proc_control;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic [15:0] din = '0;
    logic        g_nz = 1'b0;
    logic [9:0]  select;
    logic [7:0]  rin;
    logic        ain, gin, addsub, busy, done;
    logic [8:0]  ir;

    typedef struct packed {
        logic [9:0] sel;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic [8:0] ir;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct packed {
        logic        rn;
        logic        run;
        logic [15:0] din;
        logic        gnz;
    } stim_t;

    obs_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    proc_control #(.WORD(16), .NREG(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .run    (run),
        .din    (din),
        .g_nz   (g_nz),
        .select (select),
        .rin    (rin),
        .ain    (ain),
        .gin    (gin),
        .addsub (addsub),
        .ir     (ir),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    function automatic obs_t e(input logic [9:0] s, input logic [7:0] r, input logic a,
                               input logic g, input logic as, input logic [8:0] i,
                               input logic b, input logic d);
        return '{sel: s, rin: r, ain: a, gin: g, addsub: as, ir: i, busy: b, done: d};
    endfunction

    function automatic obs_t idle(input logic [8:0] i);
        return e(10'b0, 8'b0, 1'b0, 1'b0, 1'b0, i, 1'b0, 1'b0);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("sel=%b rin=%b ain=%b gin=%b addsub=%b ir=%h busy=%b done=%b",
                         o.sel, o.rin, o.ain, o.gin, o.addsub, o.ir, o.busy, o.done);
    endfunction

    function automatic obs_t observe();
        return {select, rin, ain, gin, addsub, ir, busy, done};
    endfunction

    // Inputs change just after the rising edge; outputs are read at the falling edge.
    task automatic drive(input stim_t s);
        @(posedge clock);
        #1;
        resetn = s.rn;
        run    = s.run;
        din    = s.din;
        g_nz   = s.gnz;
        @(negedge clock);
    endtask

    task automatic test_reset();
        stim_t st[2];
        obs_t  ex[2];
        obs_t  got, want;
        drive('{1'b0, 1'b0, 16'h0000, 1'b0});
        st = '{'{1'b1, 1'b0, 16'h0000, 1'b0}, '{1'b1, 1'b0, 16'h01FF, 1'b1}};
        ex = '{idle(9'h000), idle(9'h000)};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = observe();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset step %0d: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_mid_add();
        stim_t st[5];
        obs_t  ex[5];
        obs_t  got, want;
        st = '{'{1'b1, 1'b1, 16'h008A, 1'b0}, '{1'b1, 1'b0, 16'h0000, 1'b0},
               '{1'b0, 1'b0, 16'h0000, 1'b0}, '{1'b1, 1'b0, 16'h0000, 1'b0},
               '{1'b1, 1'b0, 16'h0000, 1'b0}};
        ex = '{idle(9'h000),
               e(10'b0000001000, 8'b0, 1'b1, 1'b0, 1'b0, 9'h08A, 1'b1, 1'b0),
               e(10'b0000010000, 8'b0, 1'b0, 1'b1, 1'b0, 9'h08A, 1'b1, 1'b0),
               idle(9'h000), idle(9'h000)};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = observe();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid_add step %0d: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_mvi();
        stim_t st[3];
        obs_t  ex[3];
        obs_t  got, want;
        st = '{'{1'b1, 1'b1, 16'h0058, 1'b0}, '{1'b1, 1'b0, 16'h00A5, 1'b0},
               '{1'b1, 1'b0, 16'h0000, 1'b0}};
        ex = '{idle(9'h000),
               e(10'b0000000001, 8'b00001000, 1'b0, 1'b0, 1'b0, 9'h058, 1'b1, 1'b1),
               idle(9'h058)};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = observe();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mvi step %0d: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_add_sub();
        stim_t st[10];
        obs_t  ex[10];
        obs_t  got, want;
        st = '{'{1'b1, 1'b1, 16'h0081, 1'b0}, '{1'b1, 1'b0, 16'h0000, 1'b0},
               '{1'b1, 1'b0, 16'h0000, 1'b0}, '{1'b1, 1'b0, 16'h0000, 1'b0},
               '{1'b1, 1'b1, 16'h00FF, 1'b0}, '{1'b1, 1'b0, 16'h0000, 1'b0},
               '{1'b1, 1'b0, 16'h0000, 1'b0}, '{1'b1, 1'b0, 16'h0000, 1'b0},
               '{1'b1, 1'b0, 16'h0000, 1'b0}, '{1'b1, 1'b0, 16'h0000, 1'b0}};
        ex = '{idle(9'h058),
               e(10'b0000000100, 8'b0,        1'b1, 1'b0, 1'b0, 9'h081, 1'b1, 1'b0),
               e(10'b0000001000, 8'b0,        1'b0, 1'b1, 1'b0, 9'h081, 1'b1, 1'b0),
               e(10'b0000000010, 8'b00000001, 1'b0, 1'b0, 1'b0, 9'h081, 1'b1, 1'b1),
               idle(9'h081),
               e(10'b1000000000, 8'b0,        1'b1, 1'b0, 1'b0, 9'h0FF, 1'b1, 1'b0),
               e(10'b1000000000, 8'b0,        1'b0, 1'b1, 1'b1, 9'h0FF, 1'b1, 1'b0),
               e(10'b0000000010, 8'b10000000, 1'b0, 1'b0, 1'b0, 9'h0FF, 1'b1, 1'b1),
               idle(9'h0FF), idle(9'h0FF)};
        for (int i = 0; i < 10; i++) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = observe();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL add_sub step %0d: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_mvnz();
        stim_t st[5];
        obs_t  ex[5];
        obs_t  got, want;
        st = '{'{1'b1, 1'b1, 16'h0115, 1'b0}, '{1'b1, 1'b0, 16'h0000, 1'b0},
               '{1'b1, 1'b1, 16'h0115, 1'b1}, '{1'b1, 1'b0, 16'h0000, 1'b1},
               '{1'b1, 1'b0, 16'h0000, 1'b1}};
        ex = '{idle(9'h0FF),
               e(10'b0,          8'b0,        1'b0, 1'b0, 1'b0, 9'h115, 1'b1, 1'b1),
               idle(9'h115),
               e(10'b0010000000, 8'b00000100, 1'b0, 1'b0, 1'b0, 9'h115, 1'b1, 1'b1),
               idle(9'h115)};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = observe();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mvnz step %0d: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[9];
        obs_t  ex[9];
        obs_t  got, want;
        st = '{'{1'b1, 1'b1, 16'h000A, 1'b0}, '{1'b1, 1'b1, 16'h01C0, 1'b0},
               '{1'b1, 1'b1, 16'h01C0, 1'b0}, '{1'b1, 1'b1, 16'h009C, 1'b0},
               '{1'b1, 1'b1, 16'h009C, 1'b0}, '{1'b1, 1'b0, 16'h01C0, 1'b0},
               '{1'b1, 1'b1, 16'h01C0, 1'b0}, '{1'b1, 1'b0, 16'h01C0, 1'b0},
               '{1'b1, 1'b0, 16'h01C0, 1'b0}};
        ex = '{idle(9'h115),
               e(10'b0000010000, 8'b00000010, 1'b0, 1'b0, 1'b0, 9'h00A, 1'b1, 1'b1),
               idle(9'h00A),
               e(10'b0,          8'b0,        1'b0, 1'b0, 1'b0, 9'h1C0, 1'b1, 1'b1),
               idle(9'h1C0),
               e(10'b0000100000, 8'b0,        1'b1, 1'b0, 1'b0, 9'h09C, 1'b1, 1'b0),
               e(10'b0001000000, 8'b0,        1'b0, 1'b1, 1'b0, 9'h09C, 1'b1, 1'b0),
               e(10'b0000000010, 8'b00001000, 1'b0, 1'b0, 1'b0, 9'h09C, 1'b1, 1'b1),
               idle(9'h09C)};
        for (int i = 0; i < 9; i++) begin
            sb.push_back(ex[i]);
            drive(st[i]);
            got  = observe();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL back_to_back step %0d: got %s, expected %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_add();
        test_mvi();
        test_add_sub();
        test_mvnz();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
